ysyx_22041207_muldiv_ctrl: RTL
==============================

# ysyx_22041207_muldiv_ctrl

Sequencer for the EX-stage multi-cycle M-extension operations. It accepts one MUL/DIV/REM-class request at a time from the EX stage and holds the pipeline stalled while the request is outstanding. It drives the shared multiplier and divider units over valid/ready handshakes and resolves RISC-V divide corner cases locally without calling a unit. It formats 32-bit (W) results and returns one registered result pulse.

## Interface
- XLEN, 64, operand/result width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; abandons any request.
- req_valid  in  1  EX has an M-op.
- req_ready  out  1  controller can accept; equals (state==IDLE).
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_word  in  1  W variant (32-bit).
- req_a, req_b  in  XLEN  rs1/rs2 values.
- stall  out  1  hold EX/upstream.
- resp_valid  out  1  one-cycle result pulse.
- resp_res  out  XLEN  result, valid with resp_valid.
- mul_valid  out  1;  mul_ready  in  1;  mul_sign  out  2 ({a_signed,b_signed});  mul_a, mul_b  out  XLEN.
- mul_out_valid  in  1;  mul_hi, mul_lo  in  XLEN.
- div_valid  out  1;  div_ready  in  1;  div_sign  out  1;  div_a, div_b  out  XLEN.
- div_out_valid  in  1;  div_quot, div_rem  in  XLEN.
- unit_kill  out  1  one-cycle abort pulse to both units.

## Operation
- States: IDLE, MUL_ISSUE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, DONE.
- Accept in IDLE when req_valid & ~flush. Latch op, word, and formatted operands.
- Operand formatting: when word=1, signed ops sign-extend [31:0] and unsigned ops zero-extend [31:0]. When word=0, operands pass through unchanged.
- mul_sign: MUL/MULH 11, MULHSU 10, MULHU 00. div_sign is 1 for DIV/REM and 0 otherwise.
- Routing: op<4 goes to MUL_ISSUE. op>=4 goes to DIV_ISSUE unless a corner case applies, in which case it goes straight to DONE.
- Divide-by-zero (b==0, checked on the effective width): quotient is all ones, remainder is a.
- Signed overflow (a==most-negative and b==-1 at the effective width, signed ops only): quotient is a, remainder is 0.
- ISSUE states: assert valid with stable operands until ready is high on a rising edge, then move to WAIT.
- WAIT states: on out_valid, capture the result and move to DONE.
- Result selection: MUL takes lo. MULH* take hi. DIV* take quot. REM* take rem.
- W results: [31:0] is sign-extended to 64 bits.
- DONE: assert resp_valid for one cycle, then return to IDLE.
- out_valid is ignored in any state other than the matching WAIT.
- Flush in ISSUE/WAIT: go to IDLE and pulse unit_kill for 1 cycle. No response is produced.
- Flush in DONE: suppress resp_valid and go to IDLE.
- Flush in IDLE: the request is not accepted.
- stall = (state in ISSUE/WAIT) | (state==IDLE & req_valid & ~flush). stall is 0 in DONE, so EX advances in the resp_valid cycle.
- Requests cannot overlap. The next accept is possible in the cycle after DONE.

## Timing
- Reset (rst low, async): state is IDLE. All registered outputs are 0 (resp_valid, resp_res, mul_valid, div_valid, unit_kill, operand outputs). req_ready reads 1 during reset.
- Accept at cycle N:
  - Corner case: resp_valid at N+1.
  - Unit op: valid high from N+1. With ready at cycle H and out_valid at cycle W>H, resp_valid is at W+1.
  - Minimum unit-path latency is 3 cycles with ready and out_valid asserted as early as allowed.
- resp_res holds its value until the next capture.
- unit_kill is asserted in the cycle after flush is sampled.
- Reset asserted mid-operation: immediate return to IDLE, with no kill pulse and no response.

## Test plan
- MUL a=7, b=6, word=0; mul_ready immediate, out_valid 2 cycles later -> resp_res=42, single resp_valid, stall low in that cycle.
- MULH a=b=0xFFFF_FFFF_FFFF_FFFF (mul_hi=0, mul_lo=1) -> mul_sign=11, resp_res=0. MULHU with the same operands (unit returns hi=0xFFFF_FFFF_FFFF_FFFE) -> mul_sign=00, resp_res=0xFFFF_FFFF_FFFF_FFFE.
- DIVU a=100, b=0 -> no div_valid, resp_valid at N+1 with 0xFFFF_FFFF_FFFF_FFFF. REM a=-5, b=0 -> resp_res=-5.
- DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF -> overflow, resp_res=0xFFFF_FFFF_8000_0000. REMW with the same operands -> 0.
- DIV in DIV_WAIT, flush asserted -> unit_kill 1 cycle, IDLE, no resp_valid. A subsequent late div_out_valid is ignored.
- Back-to-back REMUW a=0x1_0000_0007, b=3 (div_a=7, div_rem=1 -> resp_res=1) then MUL -> second accept the cycle after DONE. mul_valid is held through 3 cycles of mul_ready=0 with stable operands.

Source files
------------

// File: rtl/ysyx_22041207_muldiv_ctrl_if.sv
// Bundle between the EX stage, the M-op controller and the shared multiplier/divider units.
// slave is the controller's view; master is the EX stage plus the two units.
interface ysyx_22041207_muldiv_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic [XLEN-1:0] resp_res;

  logic            mul_valid;
  logic            mul_ready;
  logic [1:0]      mul_sign;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic            mul_out_valid;
  logic [XLEN-1:0] mul_hi;
  logic [XLEN-1:0] mul_lo;

  logic            div_valid;
  logic            div_ready;
  logic            div_sign;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_out_valid;
  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rem;

  modport slave (
    input  req_valid, req_op, req_word, req_a, req_b,
    input  mul_ready, mul_out_valid, mul_hi, mul_lo,
    input  div_ready, div_out_valid, div_quot, div_rem,
    output req_ready, resp_valid, resp_res,
    output mul_valid, mul_sign, mul_a, mul_b,
    output div_valid, div_sign, div_a, div_b
  );

  modport master (
    output req_valid, req_op, req_word, req_a, req_b,
    output mul_ready, mul_out_valid, mul_hi, mul_lo,
    output div_ready, div_out_valid, div_quot, div_rem,
    input  req_ready, resp_valid, resp_res,
    input  mul_valid, mul_sign, mul_a, mul_b,
    input  div_valid, div_sign, div_a, div_b
  );
endinterface

// File: rtl/ysyx_22041207_muldiv_ctrl.sv
// EX-stage sequencer for M-extension ops: issues to the shared mul/div units, resolves divide
// corner cases locally, formats W results and returns a single result pulse.
module ysyx_22041207_muldiv_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  output logic                           o_stall,
  output logic                           o_unit_kill,
  ysyx_22041207_muldiv_ctrl_if.slave     io_bus
);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;

  typedef enum logic [2:0] {
    StIdle, StMulIssue, StMulWait, StDivIssue, StDivWait, StDone
  } state_e;

  state_e          r_state, w_state_next;
  logic [2:0]      r_op;
  logic            r_word;
  logic [XLEN-1:0] r_a, r_b, r_res;
  logic            r_kill;

  logic            w_accept, w_busy, w_capture, w_is_div, w_a_signed, w_b_signed;
  logic            w_div_zero, w_ovf, w_corner;
  logic [XLEN-1:0] w_fa, w_fb, w_corner_res, w_unit_res;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    ext32 = sgn ? {{(XLEN-32){v[31]}}, v} : {{(XLEN-32){1'b0}}, v};
  endfunction

  function automatic logic [XLEN-1:0] fmt_res(input logic word, input logic [XLEN-1:0] v);
    fmt_res = word ? ext32(v[31:0], 1'b1) : v;
  endfunction

  // Request decode; op[2] selects divide, op[0] marks unsigned divide, op[1] marks remainder.
  always_comb begin
    w_is_div   = io_bus.req_op[2];
    w_a_signed = w_is_div ? ~io_bus.req_op[0] : (io_bus.req_op != OpMulhu);
    w_b_signed = w_is_div ? ~io_bus.req_op[0]
                          : (io_bus.req_op == OpMul || io_bus.req_op == OpMulh);
    w_fa = io_bus.req_word ? ext32(io_bus.req_a[31:0], w_a_signed) : io_bus.req_a;
    w_fb = io_bus.req_word ? ext32(io_bus.req_b[31:0], w_b_signed) : io_bus.req_b;
    w_div_zero = (w_fb == '0);
    w_ovf = ~io_bus.req_op[0] &
            (io_bus.req_word ? (w_fa[31:0] == 32'h8000_0000 && w_fb[31:0] == 32'hFFFF_FFFF)
                             : (w_fa == {1'b1, {(XLEN-1){1'b0}}} && w_fb == '1));
    w_corner = w_is_div & (w_div_zero | w_ovf);
    if (w_div_zero) w_corner_res = io_bus.req_op[1] ? w_fa : '1;
    else            w_corner_res = io_bus.req_op[1] ? '0 : w_fa;

    if (r_op[2])            w_unit_res = r_op[1] ? io_bus.div_rem : io_bus.div_quot;
    else if (r_op == OpMul) w_unit_res = io_bus.mul_lo;
    else                    w_unit_res = io_bus.mul_hi;

    w_accept  = (r_state == StIdle) & io_bus.req_valid & ~i_flush;
    w_busy    = (r_state == StMulIssue) | (r_state == StMulWait) |
                (r_state == StDivIssue) | (r_state == StDivWait);
    w_capture = ~i_flush & (((r_state == StMulWait) & io_bus.mul_out_valid) |
                            ((r_state == StDivWait) & io_bus.div_out_valid));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!w_is_div)    w_state_next = StMulIssue;
          else if (w_corner) w_state_next = StDone;
          else               w_state_next = StDivIssue;
        end
      end
      StMulIssue: if (i_flush) w_state_next = StIdle;
                  else if (io_bus.mul_ready) w_state_next = StMulWait;
      StMulWait:  if (i_flush) w_state_next = StIdle;
                  else if (io_bus.mul_out_valid) w_state_next = StDone;
      StDivIssue: if (i_flush) w_state_next = StIdle;
                  else if (io_bus.div_ready) w_state_next = StDivWait;
      StDivWait:  if (i_flush) w_state_next = StIdle;
                  else if (io_bus.div_out_valid) w_state_next = StDone;
      StDone:     w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op   <= '0;
      r_word <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_kill <= 1'b0;
    end else begin
      r_kill <= w_busy & i_flush;
      if (w_accept) begin
        r_op   <= io_bus.req_op;
        r_word <= io_bus.req_word;
        r_a    <= w_fa;
        r_b    <= w_fb;
        if (w_corner) r_res <= fmt_res(io_bus.req_word, w_corner_res);
      end else if (w_capture) begin
        r_res <= fmt_res(r_word, w_unit_res);
      end
    end
  end

  always_comb begin
    io_bus.req_ready  = (r_state == StIdle);
    io_bus.resp_valid = (r_state == StDone) & ~i_flush;
    io_bus.resp_res   = r_res;
    io_bus.mul_valid  = (r_state == StMulIssue);
    io_bus.div_valid  = (r_state == StDivIssue);
    io_bus.mul_a      = r_a;
    io_bus.mul_b      = r_b;
    io_bus.div_a      = r_a;
    io_bus.div_b      = r_b;
    io_bus.div_sign   = r_op[2] & ~r_op[0];
    if (r_op == OpMul || r_op == OpMulh) io_bus.mul_sign = 2'b11;
    else if (r_op == OpMulhsu)           io_bus.mul_sign = 2'b10;
    else                                 io_bus.mul_sign = 2'b00;
    o_stall     = w_busy | w_accept;
    o_unit_kill = r_kill;
  end

endmodule
